// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving an external 8-bit ALU.
// Owns the PC, the 4x8 register file, and the IR/RES/TAKEN latches.
module alu_sequencer #(
  parameter int          PC_W    = 8,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic [PC_W-1:0] inst_addr,
  input  logic [8:0]      inst_data,
  output logic [4:0]      OP,
  output logic [7:0]      inOne,
  output logic [7:0]      inTwo,
  output logic            fourShift,
  input  logic [7:0]      result,
  input  logic            branchCompPass,
  input  logic            pre_we,
  input  logic [1:0]      pre_addr,
  input  logic [7:0]      pre_data,
  input  logic [1:0]      dbg_addr,
  output logic [7:0]      dbg_data
);

  localparam logic [4:0] OP_BZ  = 5'b10100;
  localparam logic [4:0] OP_BNZ = 5'b11000;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [3:0][7:0] rf_q;
  logic [8:0]      ir_q;
  logic [7:0]      res_q;
  logic            taken_q;
  logic            done_q;
  logic [4:0]      op_q;
  logic [7:0]      ina_q;
  logic [7:0]      inb_q;

  logic            ir_branch;
  logic [PC_W-1:0] pc_inc_d;
  logic [PC_W-1:0] pc_wb_d;
  logic            unused_ir_rb;

  assign ir_branch = (ir_q[8:4] == OP_BZ) || (ir_q[8:4] == OP_BNZ);
  assign pc_inc_d  = pc_q + PC_W'(1);
  // RES carries the absolute branch target (the ALU forwards rb)
  assign pc_wb_d   = (ir_branch && taken_q) ? PC_W'(res_q) : pc_inc_d;

  // rb is consumed straight from inst_data when operands are registered
  assign unused_ir_rb = ^ir_q[1:0];

  assign inst_addr = pc_q;
  assign done      = done_q;
  assign OP        = op_q;
  assign inOne     = ina_q;
  assign inTwo     = inb_q;
  assign fourShift = 1'b0;
  assign dbg_data  = rf_q[dbg_addr];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      rf_q    <= '0;
      ir_q    <= '0;
      res_q   <= '0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pre_we) rf_q[pre_addr] <= pre_data;
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q <= inst_data;
          if (inst_data[8:4] == HALT_OP) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            // operands are registered here so they hold steady across EXEC
            state_q <= S_EXEC;
            op_q    <= inst_data[8:4];
            ina_q   <= rf_q[inst_data[3:2]];
            inb_q   <= rf_q[inst_data[1:0]];
          end
        end
        S_EXEC: begin
          res_q <= result;
          if (ir_branch) taken_q <= branchCompPass;
          op_q    <= '0;
          ina_q   <= '0;
          inb_q   <= '0;
          state_q <= S_WB;
        end
        S_WB: begin
          if (!ir_branch) rf_q[ir_q[3:2]] <= res_q;
          pc_q    <= pc_wb_d;
          state_q <= S_FETCH;
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
